// File: rtl/cnn_layer_accel_pkg.sv
// rtl/cnn_layer_accel_pkg.sv - shared widths and packer FSM states
package cnn_layer_accel_pkg;

    localparam int C_RESULT_WIDTH = 16;
    localparam int C_PACK_LANES   = 8;
    localparam int C_ROW_W        = 10;
    localparam int C_COL_W        = 10;
    localparam int C_DEPTH_W      = 8;
    localparam int C_REMAIN_W     = 26;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } packer_state_e;

endpackage

// File: rtl/cnn_layer_accel_coord_cnt.sv
// rtl/cnn_layer_accel_coord_cnt.sv - row/col/depth wrap counter, depth innermost
module cnn_layer_accel_coord_cnt
    import cnn_layer_accel_pkg::*;
(
    input  logic                 clk_if,
    input  logic                 rst_n,
    input  logic                 clear_i,
    input  logic                 step_i,
    input  logic [C_ROW_W-1:0]   num_rows_i,
    input  logic [C_COL_W-1:0]   num_cols_i,
    input  logic [C_DEPTH_W-1:0] num_kernels_i,
    output logic [C_ROW_W-1:0]   row_o,
    output logic [C_COL_W-1:0]   col_o,
    output logic [C_DEPTH_W-1:0] depth_o
);

    logic [C_ROW_W-1:0]   row_q, row_d;
    logic [C_COL_W-1:0]   col_q, col_d;
    logic [C_DEPTH_W-1:0] depth_q, depth_d;

    // Next coordinate: depth wraps into column, column wraps into row.
    always_comb begin
        row_d   = row_q;
        col_d   = col_q;
        depth_d = depth_q;
        if (clear_i) begin
            row_d   = '0;
            col_d   = '0;
            depth_d = '0;
        end else if (step_i) begin
            if (depth_q == num_kernels_i - C_DEPTH_W'(1)) begin
                depth_d = '0;
                if (col_q == num_cols_i - C_COL_W'(1)) begin
                    col_d = '0;
                    if (row_q == num_rows_i - C_ROW_W'(1)) begin
                        row_d = '0;
                    end else begin
                        row_d = row_q + C_ROW_W'(1);
                    end
                end else begin
                    col_d = col_q + C_COL_W'(1);
                end
            end else begin
                depth_d = depth_q + C_DEPTH_W'(1);
            end
        end
    end

    // Coordinate registers.
    always_ff @(posedge clk_if or negedge rst_n) begin
        if (!rst_n) begin
            row_q   <= '0;
            col_q   <= '0;
            depth_q <= '0;
        end else begin
            row_q   <= row_d;
            col_q   <= col_d;
            depth_q <= depth_d;
        end
    end

    assign row_o   = row_q;
    assign col_o   = col_q;
    assign depth_o = depth_q;

endmodule

// File: rtl/cnn_layer_accel_result_packer.sv
// rtl/cnn_layer_accel_result_packer.sv - packs convolution results into wide output beats
module cnn_layer_accel_result_packer #(
    parameter int C_RESULT_WIDTH = cnn_layer_accel_pkg::C_RESULT_WIDTH,
    parameter int C_PACK_LANES   = cnn_layer_accel_pkg::C_PACK_LANES
) (
    input  logic                                       clk_if,
    input  logic                                       rst_n,
    input  logic                                       cfg_valid,
    output logic                                       cfg_ready,
    input  logic [cnn_layer_accel_pkg::C_ROW_W-1:0]    cfg_num_output_rows,
    input  logic [cnn_layer_accel_pkg::C_COL_W-1:0]    cfg_num_output_cols,
    input  logic [cnn_layer_accel_pkg::C_DEPTH_W-1:0]  cfg_num_kernels,
    input  logic                                       result_valid,
    output logic                                       result_accept,
    input  logic [C_RESULT_WIDTH-1:0]                  result_data,
    output logic                                       pack_valid,
    input  logic                                       pack_ready,
    output logic [C_RESULT_WIDTH*C_PACK_LANES-1:0]     pack_data,
    output logic [C_PACK_LANES-1:0]                    pack_keep,
    output logic                                       pack_last,
    output logic [cnn_layer_accel_pkg::C_ROW_W-1:0]    out_row,
    output logic [cnn_layer_accel_pkg::C_COL_W-1:0]    out_col,
    output logic [cnn_layer_accel_pkg::C_DEPTH_W-1:0]  out_depth,
    output logic                                       job_done
);

    import cnn_layer_accel_pkg::packer_state_e;
    import cnn_layer_accel_pkg::ST_IDLE;
    import cnn_layer_accel_pkg::ST_RUN;
    import cnn_layer_accel_pkg::ST_FLUSH;
    import cnn_layer_accel_pkg::C_ROW_W;
    import cnn_layer_accel_pkg::C_COL_W;
    import cnn_layer_accel_pkg::C_DEPTH_W;
    import cnn_layer_accel_pkg::C_REMAIN_W;

    localparam int DW = C_RESULT_WIDTH * C_PACK_LANES;
    localparam int LW = $clog2(C_PACK_LANES);

    packer_state_e        state_q, state_d;
    logic [C_ROW_W-1:0]   rows_q, rows_d;
    logic [C_COL_W-1:0]   cols_q, cols_d;
    logic [C_DEPTH_W-1:0] kern_q, kern_d;
    logic                 zero_job_q, zero_job_d;
    logic                 job_done_q, job_done_d;

    logic [C_REMAIN_W-1:0] remain_q, remain_d;

    // Accumulator: word being filled, or a completed word waiting for the output register.
    logic [DW-1:0]           acc_data_q, acc_data_d;
    logic [C_PACK_LANES-1:0] acc_keep_q, acc_keep_d;
    logic [LW-1:0]           acc_lane_q, acc_lane_d;
    logic                    acc_full_q, acc_full_d;
    logic                    acc_last_q, acc_last_d;

    // Output register driving the packed stream.
    logic [DW-1:0]           out_data_q, out_data_d;
    logic [C_PACK_LANES-1:0] out_keep_q, out_keep_d;
    logic                    out_last_q, out_last_d;
    logic                    out_valid_q, out_valid_d;

    logic                    cfg_fire;
    logic                    accept;
    logic                    out_free;
    logic                    pack_fire;
    logic                    final_result;
    logic [DW-1:0]           wr_data;
    logic [C_PACK_LANES-1:0] wr_keep;
    logic                    wr_done;

    assign cfg_ready     = (state_q == ST_IDLE);
    assign cfg_fire      = cfg_valid && cfg_ready;
    assign result_accept = (state_q == ST_RUN) && !acc_full_q;
    assign accept        = result_valid && result_accept;
    assign pack_fire     = out_valid_q && pack_ready;
    assign out_free      = !out_valid_q || pack_ready;
    assign final_result  = (remain_q == C_REMAIN_W'(1));

    // Accumulator contents if the current result is written into the next lane.
    always_comb begin
        wr_data = acc_data_q;
        wr_keep = acc_keep_q;
        wr_data[acc_lane_q*C_RESULT_WIDTH +: C_RESULT_WIDTH] = result_data;
        wr_keep[acc_lane_q] = 1'b1;
        wr_done = (acc_lane_q == LW'(C_PACK_LANES - 1)) || final_result;
    end

    // Job FSM: latch configuration, run until the last result, flush until the last beat leaves.
    always_comb begin
        state_d    = state_q;
        rows_d     = rows_q;
        cols_d     = cols_q;
        kern_d     = kern_q;
        zero_job_d = zero_job_q;
        job_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cfg_valid) begin
                    rows_d     = cfg_num_output_rows;
                    cols_d     = cfg_num_output_cols;
                    kern_d     = cfg_num_kernels;
                    zero_job_d = (cfg_num_output_rows == '0) || (cfg_num_output_cols == '0) ||
                                 (cfg_num_kernels == '0);
                    state_d    = zero_job_d ? ST_FLUSH : ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept && final_result) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (zero_job_q || (pack_fire && out_last_q)) begin
                    job_done_d = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath: fill lanes, hand completed words to the output register when it can take them.
    always_comb begin
        remain_d    = remain_q;
        acc_data_d  = acc_data_q;
        acc_keep_d  = acc_keep_q;
        acc_lane_d  = acc_lane_q;
        acc_full_d  = acc_full_q;
        acc_last_d  = acc_last_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;

        if (pack_fire) begin
            out_valid_d = 1'b0;
        end

        if (cfg_fire) begin
            remain_d   = C_REMAIN_W'(cfg_num_output_rows) * C_REMAIN_W'(cfg_num_output_cols) *
                         C_REMAIN_W'(cfg_num_kernels);
            acc_data_d = '0;
            acc_keep_d = '0;
            acc_lane_d = '0;
            acc_full_d = 1'b0;
            acc_last_d = 1'b0;
        end else if (accept) begin
            remain_d = remain_q - C_REMAIN_W'(1);
            if (wr_done && out_free) begin
                out_data_d  = wr_data;
                out_keep_d  = wr_keep;
                out_last_d  = final_result;
                out_valid_d = 1'b1;
                acc_data_d  = '0;
                acc_keep_d  = '0;
                acc_lane_d  = '0;
                acc_last_d  = 1'b0;
            end else if (wr_done) begin
                acc_data_d = wr_data;
                acc_keep_d = wr_keep;
                acc_full_d = 1'b1;
                acc_last_d = final_result;
            end else begin
                acc_data_d = wr_data;
                acc_keep_d = wr_keep;
                acc_lane_d = acc_lane_q + LW'(1);
            end
        end else if (acc_full_q && out_free) begin
            out_data_d  = acc_data_q;
            out_keep_d  = acc_keep_q;
            out_last_d  = acc_last_q;
            out_valid_d = 1'b1;
            acc_data_d  = '0;
            acc_keep_d  = '0;
            acc_lane_d  = '0;
            acc_full_d  = 1'b0;
            acc_last_d  = 1'b0;
        end
    end

    // FSM and configuration registers.
    always_ff @(posedge clk_if or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rows_q     <= '0;
            cols_q     <= '0;
            kern_q     <= '0;
            zero_job_q <= 1'b0;
            job_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rows_q     <= rows_d;
            cols_q     <= cols_d;
            kern_q     <= kern_d;
            zero_job_q <= zero_job_d;
            job_done_q <= job_done_d;
        end
    end

    // Counter, accumulator and output registers.
    always_ff @(posedge clk_if or negedge rst_n) begin
        if (!rst_n) begin
            remain_q    <= '0;
            acc_data_q  <= '0;
            acc_keep_q  <= '0;
            acc_lane_q  <= '0;
            acc_full_q  <= 1'b0;
            acc_last_q  <= 1'b0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            remain_q    <= remain_d;
            acc_data_q  <= acc_data_d;
            acc_keep_q  <= acc_keep_d;
            acc_lane_q  <= acc_lane_d;
            acc_full_q  <= acc_full_d;
            acc_last_q  <= acc_last_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
        end
    end

    cnn_layer_accel_coord_cnt u_coord_cnt (
        .clk_if        (clk_if),
        .rst_n         (rst_n),
        .clear_i       (cfg_fire),
        .step_i        (accept),
        .num_rows_i    (rows_q),
        .num_cols_i    (cols_q),
        .num_kernels_i (kern_q),
        .row_o         (out_row),
        .col_o         (out_col),
        .depth_o       (out_depth)
    );

    assign pack_valid = out_valid_q;
    assign pack_data  = out_data_q;
    assign pack_keep  = out_keep_q;
    assign pack_last  = out_last_q;
    assign job_done   = job_done_q;

endmodule

// File: tb/tb_cnn_layer_accel_result_packer.sv
// tb/tb_cnn_layer_accel_result_packer.sv - directed self-checking bench for the result packer
module tb_cnn_layer_accel_result_packer;

    logic         clk_if = 1'b0;
    logic         rst_n = 1'b0;
    logic         cfg_valid = 1'b0;
    logic         cfg_ready;
    logic [9:0]   cfg_num_output_rows = '0;
    logic [9:0]   cfg_num_output_cols = '0;
    logic [7:0]   cfg_num_kernels = '0;
    logic         result_valid = 1'b0;
    logic         result_accept;
    logic [15:0]  result_data = '0;
    logic         pack_valid;
    logic         pack_ready = 1'b1;
    logic [127:0] pack_data;
    logic [7:0]   pack_keep;
    logic         pack_last;
    logic [9:0]   out_row;
    logic [9:0]   out_col;
    logic [7:0]   out_depth;
    logic         job_done;

    always #5 clk_if = ~clk_if;

    cnn_layer_accel_result_packer dut (
        .clk_if              (clk_if),
        .rst_n               (rst_n),
        .cfg_valid           (cfg_valid),
        .cfg_ready           (cfg_ready),
        .cfg_num_output_rows (cfg_num_output_rows),
        .cfg_num_output_cols (cfg_num_output_cols),
        .cfg_num_kernels     (cfg_num_kernels),
        .result_valid        (result_valid),
        .result_accept       (result_accept),
        .result_data         (result_data),
        .pack_valid          (pack_valid),
        .pack_ready          (pack_ready),
        .pack_data           (pack_data),
        .pack_keep           (pack_keep),
        .pack_last           (pack_last),
        .out_row             (out_row),
        .out_col             (out_col),
        .out_depth           (out_depth),
        .job_done            (job_done)
    );

    int checks = 0;
    int failures = 0;

    int mon_res, mon_words, mon_beats, mon_done, mon_total, stab_err, acc_err;
    logic         prev_stall;
    logic [127:0] prev_data;
    logic [7:0]   prev_keep;
    logic         prev_last;
    logic [127:0] beat_data[$];
    logic [8:0]   beat_ctl[$];

    bit rnd_mode = 1'b0;
    int job_seed = 0;
    int tx_idx = 0;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] res_val(input int k);
        int v;
        v = k * 37 + 5;
        return v[15:0];
    endfunction

    task automatic mon_clear();
        mon_res = 0; mon_words = 0; mon_beats = 0; mon_done = 0;
        stab_err = 0; acc_err = 0; prev_stall = 1'b0;
        beat_data.delete();
        beat_ctl.delete();
    endtask

    // Stream observer: beats, stall stability, back-pressure on the result side, done pulses.
    always @(negedge clk_if) begin
        if (rst_n) begin
            if (prev_stall && (!pack_valid || pack_data !== prev_data ||
                               pack_keep !== prev_keep || pack_last !== prev_last))
                stab_err++;
            prev_stall = pack_valid && !pack_ready;
            prev_data  = pack_data;
            prev_keep  = pack_keep;
            prev_last  = pack_last;
            if ((mon_words - mon_beats) >= 2 && result_accept)
                acc_err++;
            if (result_valid && result_accept) begin
                mon_res++;
                if ((mon_res % 8) == 0 || mon_res == mon_total)
                    mon_words++;
            end
            if (pack_valid && pack_ready) begin
                beat_data.push_back(pack_data);
                beat_ctl.push_back({pack_last, pack_keep});
                mon_beats++;
            end
            if (job_done)
                mon_done++;
        end
    end

    // Output back-pressure: always ready, or a coin flip per cycle.
    initial begin
        forever begin
            @(posedge clk_if);
            #1;
            pack_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic do_cfg(input int r, input int c, input int k);
        bit hs;
        int g;
        mon_clear();
        mon_total = r * c * k;
        tx_idx = 0;
        cfg_valid = 1'b1;
        cfg_num_output_rows = 10'(r);
        cfg_num_output_cols = 10'(c);
        cfg_num_kernels = 8'(k);
        hs = 1'b0;
        g = 0;
        while (!hs && g < 100) begin
            @(negedge clk_if);
            hs = cfg_ready;
            @(posedge clk_if);
            #1;
            g++;
        end
        cfg_valid = 1'b0;
        check_eq("cfg_handshake", 128'(hs), 128'd1);
    endtask

    task automatic send_results(input int n);
        int sent;
        int guard;
        bit fire;
        sent = 0;
        guard = 0;
        while (sent < n && guard < 20000) begin
            result_valid = 1'b1;
            result_data = res_val(job_seed + tx_idx);
            @(negedge clk_if);
            fire = result_accept;
            @(posedge clk_if);
            #1;
            if (fire) begin
                sent++;
                tx_idx++;
            end
            guard++;
        end
        result_valid = 1'b0;
        check_eq("results_sent", 128'(sent), 128'(n));
    endtask

    task automatic wait_done(input int budget);
        int g;
        g = 0;
        while (mon_done == 0 && g < budget) begin
            @(negedge clk_if);
            g++;
        end
        repeat (5) @(negedge clk_if);
        @(posedge clk_if);
        #1;
    endtask

    task automatic check_job(input int total);
        int nb;
        int lanes;
        logic [127:0] exp_d;
        logic [8:0]   exp_c;
        nb = (total + 7) / 8;
        check_eq("beat_count", 128'(mon_beats), 128'(nb));
        for (int b = 0; b < nb && b < beat_data.size(); b++) begin
            lanes = (total - 8 * b) > 8 ? 8 : (total - 8 * b);
            exp_d = '0;
            for (int k = 0; k < lanes; k++)
                exp_d[16*k +: 16] = res_val(job_seed + 8 * b + k);
            exp_c = {(b == nb - 1), 8'((1 << lanes) - 1)};
            check_eq($sformatf("beat%0d_data", b), beat_data[b], exp_d);
            check_eq($sformatf("beat%0d_last_keep", b), 128'(beat_ctl[b]), 128'(exp_c));
        end
        check_eq("job_done_pulses", 128'(mon_done), 128'd1);
        check_eq("stall_stability_errors", 128'(stab_err), 128'd0);
        check_eq("accept_while_full_errors", 128'(acc_err), 128'd0);
        check_eq("cfg_ready_after_job", 128'(cfg_ready), 128'd1);
    endtask

    task automatic check_outputs_zero(input string pfx);
        check_eq({pfx, "_pack_valid"}, 128'(pack_valid), 128'd0);
        check_eq({pfx, "_pack_data"}, pack_data, 128'd0);
        check_eq({pfx, "_pack_keep_last"}, 128'({pack_last, pack_keep}), 128'd0);
        check_eq({pfx, "_result_accept"}, 128'(result_accept), 128'd0);
        check_eq({pfx, "_job_done"}, 128'(job_done), 128'd0);
        check_eq({pfx, "_coords"}, 128'({out_row, out_col, out_depth}), 128'd0);
    endtask

    initial begin
        mon_clear();
        mon_total = 0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk_if);
        #1;
        check_outputs_zero("reset");
        rst_n = 1'b1;
        @(posedge clk_if);
        #1;
        check_eq("cfg_ready_after_reset", 128'(cfg_ready), 128'd1);

        // 2x2x2 frame: a single full beat, lanes in arrival order.
        job_seed = 1000;
        do_cfg(2, 2, 2);
        send_results(8);
        wait_done(200);
        check_job(8);

        // 17x17x2 frame with coordinate probe after 35 results.
        job_seed = 2000;
        do_cfg(17, 17, 2);
        send_results(35);
        check_eq("coords_after_35", 128'({out_row, out_col, out_depth}),
                 128'({10'd1, 10'd0, 8'd1}));
        send_results(578 - 35);
        wait_done(2000);
        check_job(578);

        // 5x5x3 frame under random back-pressure.
        rnd_mode = 1'b1;
        job_seed = 3000;
        do_cfg(5, 5, 3);
        send_results(75);
        wait_done(4000);
        check_job(75);
        rnd_mode = 1'b0;
        repeat (2) @(posedge clk_if);
        #1;

        // Zero kernels: no beats, done two cycles after the handshake.
        mon_clear();
        cfg_valid = 1'b1;
        cfg_num_output_rows = 10'd4;
        cfg_num_output_cols = 10'd4;
        cfg_num_kernels = 8'd0;
        @(negedge clk_if);
        check_eq("zero_cfg_ready", 128'(cfg_ready), 128'd1);
        @(posedge clk_if);
        #1;
        cfg_valid = 1'b0;
        @(negedge clk_if);
        check_eq("zero_done_cycle1", 128'(job_done), 128'd0);
        @(posedge clk_if);
        #1;
        @(negedge clk_if);
        check_eq("zero_done_cycle2", 128'(job_done), 128'd1);
        @(posedge clk_if);
        #1;
        @(negedge clk_if);
        check_eq("zero_done_cycle3", 128'(job_done), 128'd0);
        check_eq("zero_cfg_ready_again", 128'(cfg_ready), 128'd1);
        check_eq("zero_beats", 128'(mon_beats), 128'd0);
        @(posedge clk_if);
        #1;

        // Reset after 37 results of a 17x17x2 job, then a clean 2x2x2 job.
        job_seed = 5000;
        do_cfg(17, 17, 2);
        send_results(37);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midreset");
        repeat (2) @(posedge clk_if);
        #1;
        rst_n = 1'b1;
        @(posedge clk_if);
        #1;
        job_seed = 4000;
        do_cfg(2, 2, 2);
        send_results(8);
        wait_done(200);
        check_job(8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
